// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: port indices, response tags,
// and the word-alignment check.
package mem_arbiter_pkg;

  localparam int unsigned PORT_IF = 0;
  localparam int unsigned PORT_D  = 1;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  // Only the two low address bits decide word alignment.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-request round-robin picker.
// The grant is combinational and one-hot; the last-grant pointer is registered.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic last_q;
  logic last_d;

  // last_q = 1 means data was granted last, so fetch wins the next conflict.
  always_comb begin
    o_gnt  = i_req;
    last_d = last_q;
    if (i_req == 2'b11) begin
      o_gnt = last_q ? 2'b01 : 2'b10;
    end
    if (o_gnt[PORT_D]) begin
      last_d = 1'b1;
    end else if (o_gnt[PORT_IF]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a one-cycle-latency word memory between fetch and load/store ports.
// Misaligned accesses are rejected with an error pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned D = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_if_req,
  input  logic [D-1:0] i_if_addr,
  output logic         o_if_gnt,
  output logic         o_if_rvalid,
  output logic [W-1:0] o_if_rdata,
  output logic         o_if_err,
  input  logic         i_d_req,
  input  logic         i_d_we,
  input  logic [D-1:0] i_d_addr,
  input  logic [W-1:0] i_d_wdata,
  output logic         o_d_gnt,
  output logic         o_d_rvalid,
  output logic [W-1:0] o_d_rdata,
  output logic         o_d_err,
  output logic [D-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_data,
  output logic         o_mem_read,
  output logic         o_mem_write,
  input  logic [W-1:0] i_mem_data
);

  logic [1:0] gnt;
  tag_e       tag_q, tag_d;
  logic       if_err_q, if_err_d;
  logic       d_err_q, d_err_d;

  arb_rr2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   ({i_d_req, i_if_req}),
    .o_gnt   (gnt)
  );

  assign o_if_gnt = gnt[PORT_IF];
  assign o_d_gnt  = gnt[PORT_D];

  // Command mux toward memory plus next-state for tag and error pulses.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_data  = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    tag_d       = TAG_NONE;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    if (gnt[PORT_IF]) begin
      if (is_aligned(i_if_addr[1:0])) begin
        o_mem_addr = i_if_addr;
        o_mem_data = i_d_wdata;
        o_mem_read = 1'b1;
        tag_d      = TAG_IF;
      end else begin
        if_err_d = 1'b1;
      end
    end else if (gnt[PORT_D]) begin
      if (is_aligned(i_d_addr[1:0])) begin
        o_mem_addr  = i_d_addr;
        o_mem_data  = i_d_wdata;
        o_mem_read  = ~i_d_we;
        o_mem_write = i_d_we;
        tag_d       = i_d_we ? TAG_NONE : TAG_D;
      end else begin
        d_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tag_q    <= TAG_NONE;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      if_err_q <= if_err_d;
      d_err_q  <= d_err_d;
    end
  end

  // Responses are masked while reset is held so an in-flight read is dropped.
  assign o_if_rvalid = (tag_q == TAG_IF) && !i_reset;
  assign o_d_rvalid  = (tag_q == TAG_D) && !i_reset;
  assign o_if_err    = if_err_q && !i_reset;
  assign o_d_err     = d_err_q && !i_reset;
  assign o_if_rdata  = i_mem_data;
  assign o_d_rdata   = i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic.
// A behavioural memory model predicts every grant, strobe and response.
module tb_mem_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned NW = 64;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_if_req;
  logic [D-1:0] i_if_addr;
  logic         o_if_gnt, o_if_rvalid, o_if_err;
  logic [W-1:0] o_if_rdata;
  logic         i_d_req, i_d_we;
  logic [D-1:0] i_d_addr;
  logic [W-1:0] i_d_wdata;
  logic         o_d_gnt, o_d_rvalid, o_d_err;
  logic [W-1:0] o_d_rdata;
  logic [D-1:0] o_mem_addr;
  logic [W-1:0] o_mem_data;
  logic         o_mem_read, o_mem_write;
  logic [W-1:0] i_mem_data;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.W(W), .D(D)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .o_if_err    (o_if_err),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_rvalid  (o_d_rvalid),
    .o_d_rdata   (o_d_rdata),
    .o_d_err     (o_d_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_mem_read  (o_mem_read),
    .o_mem_write (o_mem_write),
    .i_mem_data  (i_mem_data)
  );

  // Memory block the arbiter drives: one-cycle registered read.
  logic [W-1:0] env_mem [NW];
  logic [W-1:0] mem_q;
  always @(posedge i_clk) begin
    if (o_mem_write) env_mem[o_mem_addr[D-1:2]] <= o_mem_data;
    if (o_mem_read)  mem_q <= env_mem[o_mem_addr[D-1:2]];
  end
  assign i_mem_data = mem_q;

  // Reference state.
  logic [W-1:0] ref_mem [NW];
  bit           m_last;
  bit           e_if_rv, e_d_rv, e_if_err, e_d_err;
  logic [W-1:0] e_rdata;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already applied; check mid-cycle, then advance the model.
  task automatic step(output bit g_if, output bit g_d);
    int           win;
    bit           al, rd, wr;
    logic [D-1:0] a;
    #3;
    if (i_if_req && i_d_req) win = m_last ? 1 : 2;
    else if (i_if_req)       win = 1;
    else if (i_d_req)        win = 2;
    else                     win = 0;
    a  = (win == 1) ? i_if_addr : i_d_addr;
    al = (win != 0) && (a[1:0] == 2'b00);
    rd = al && (win == 1 || !i_d_we);
    wr = al && (win == 2) && i_d_we;

    chk("if_gnt",    W'(o_if_gnt),    W'(win == 1));
    chk("d_gnt",     W'(o_d_gnt),     W'(win == 2));
    chk("mem_read",  W'(o_mem_read),  W'(rd));
    chk("mem_write", W'(o_mem_write), W'(wr));
    if (win == 0) begin
      chk("idle_addr", W'(o_mem_addr), '0);
      chk("idle_data", o_mem_data, '0);
    end else if (al) begin
      chk("mem_addr", W'(o_mem_addr), W'(a));
      if (wr) chk("mem_wdata", o_mem_data, i_d_wdata);
    end

    chk("if_rvalid", W'(o_if_rvalid), W'(e_if_rv && !i_reset));
    chk("d_rvalid",  W'(o_d_rvalid),  W'(e_d_rv && !i_reset));
    chk("if_err",    W'(o_if_err),    W'(e_if_err && !i_reset));
    chk("d_err",     W'(o_d_err),     W'(e_d_err && !i_reset));
    if (e_if_rv && !i_reset) chk("if_rdata", o_if_rdata, e_rdata);
    if (e_d_rv && !i_reset)  chk("d_rdata",  o_d_rdata,  e_rdata);

    if (rd) e_rdata = ref_mem[a[D-1:2]];
    if (i_reset) begin
      m_last = 1'b1;
      {e_if_rv, e_d_rv, e_if_err, e_d_err} = '0;
    end else begin
      e_if_rv  = rd && (win == 1);
      e_d_rv   = rd && (win == 2);
      e_if_err = (win == 1) && !al;
      e_d_err  = (win == 2) && !al;
      if (win != 0) m_last = (win == 2);
    end
    if (wr) ref_mem[a[D-1:2]] = i_d_wdata;
    g_if = (win == 1);
    g_d  = (win == 2);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_if_req = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
    i_if_addr = '0;  i_d_addr = '0;  i_d_wdata = '0;
  endtask

  bit gi, gd;

  initial begin
    for (int i = 0; i < NW; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    m_last = 1'b1;
    {e_if_rv, e_d_rv, e_if_err, e_d_err} = '0;
    e_rdata = '0;
    idle_inputs();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    step(gi, gd);
    step(gi, gd);
    i_reset = 1'b0;

    // Fetch-only stream at 0, 4, 8.
    i_if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_if_addr = D'(4 * k);
      step(gi, gd);
    end
    idle_inputs();
    step(gi, gd);

    // Contention after reset: fetch first, then alternating.
    i_reset = 1'b1;
    step(gi, gd);
    i_reset = 1'b0;
    i_if_req = 1'b1; i_if_addr = 8'h20;
    i_d_req  = 1'b1; i_d_addr  = 8'h40; i_d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(gi, gd);
      if (gi) i_if_addr = i_if_addr + 8'd4;
      if (gd) i_d_addr  = i_d_addr + 8'd4;
    end
    idle_inputs();
    step(gi, gd);

    // Store then load of the same word back to back.
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 8'h10; i_d_wdata = 32'hDEADBEEF;
    step(gi, gd);
    i_d_we = 1'b0; i_d_wdata = '0;
    step(gi, gd);
    idle_inputs();
    step(gi, gd);

    // Misaligned load, then a conflict must go to fetch.
    i_d_req = 1'b1; i_d_addr = 8'h06;
    step(gi, gd);
    idle_inputs();
    step(gi, gd);
    i_if_req = 1'b1; i_if_addr = 8'h0C; i_d_req = 1'b1; i_d_addr = 8'h14;
    step(gi, gd);
    idle_inputs();
    step(gi, gd);

    // Reset while a fetch read is in flight.
    i_if_req = 1'b1; i_if_addr = 8'h08;
    step(gi, gd);
    idle_inputs();
    i_reset = 1'b1;
    step(gi, gd);
    i_reset = 1'b0;
    step(gi, gd);
    i_if_req = 1'b1; i_if_addr = 8'h18; i_d_req = 1'b1; i_d_addr = 8'h1C;
    step(gi, gd);
    idle_inputs();
    step(gi, gd);

    // Random traffic; each port holds its request until granted.
    for (int n = 0; n < 500; n++) begin
      if (!i_if_req && ($urandom_range(0, 2) != 0)) begin
        i_if_req  = 1'b1;
        i_if_addr = D'($urandom_range(0, NW - 1) << 2);
        if ($urandom_range(0, 7) == 0) i_if_addr = i_if_addr | D'($urandom_range(1, 3));
      end
      if (!i_d_req && ($urandom_range(0, 2) != 0)) begin
        i_d_req   = 1'b1;
        i_d_we    = 1'($urandom_range(0, 1));
        i_d_wdata = $urandom;
        i_d_addr  = D'($urandom_range(0, NW - 1) << 2);
        if ($urandom_range(0, 7) == 0) i_d_addr = i_d_addr | D'($urandom_range(1, 3));
      end
      i_reset = ($urandom_range(0, 63) == 0);
      step(gi, gd);
      if (gi) i_if_req = 1'b0;
      if (gd) i_d_req  = 1'b0;
    end
    idle_inputs();
    i_reset = 1'b0;
    step(gi, gd);
    step(gi, gd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
